lsu_dmem_ctrl: RTL and testbench
================================

Name: lsu_dmem_ctrl

Overview:
- Load/store controller between the RV32I core's memory stage and the data memory (DMEM) array.
- Accepts one load/store request at a time and checks encoding, alignment and address range.
- Drives the word-organised DMEM with byte enables and lane-replicated write data.
- Returns sign- or zero-extended load data, or an error code, over a valid/ready response handshake.

Parameters:
- DMEM_BASE, 32'h0000_4000, byte address of the first DMEM byte.
- DMEM_BYTES, 49152, DMEM size in bytes; must be a multiple of 4.
- DMEM_AW, 14, DMEM word-address width; must be at least clog2(DMEM_BYTES/4).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low bits significant for byte/halfword.
- req_n_bytes  in  2  access size: 00 word, 01 byte, 10 halfword, 11 illegal.
- req_unsigned  in  1  zero-extend load data (LBU/LHU); ignored for stores and words.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal size.
- mem_en  out  1  DMEM access strobe.
- mem_we  out  1  DMEM write.
- mem_addr  out  DMEM_AW  word address = (req_addr - DMEM_BASE) >> 2.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated write data.
- mem_rdata  in  32  DMEM read data, valid in the cycle after mem_en.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Reset (rstn=0, async) forces IDLE.
- Reset values: req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_err=00; mem_en=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
- Reset mid-transaction aborts the transaction. No response is produced, and no memory strobe is issued after reset deasserts.
- req_ready=1 only in IDLE. A request is accepted on a cycle with req_valid & req_ready; all request fields are registered on acceptance.
- Error check at acceptance, priority illegal > misaligned > range:
  - illegal: n_bytes=11.
  - misaligned: word with addr[1:0]!=0, or halfword with addr[0]!=0.
  - range: addr < DMEM_BASE or addr >= DMEM_BASE+DMEM_BYTES. The comparison is done in 33 bits so it cannot wrap.
- On an error: IDLE->RESP, no mem_en pulse, rsp_rdata=0, rsp_valid rises in cycle T+1 (accept at T).
- Valid request: IDLE->ISSUE. In ISSUE (T+1), mem_en=1 for exactly one cycle; mem_we, mem_addr, mem_be and mem_wdata are registered and valid.
  - word: be=1111, wdata=data.
  - byte: be=0001<<addr[1:0], wdata={4{data[7:0]}}.
  - halfword: be=addr[1]?1100:0011, wdata={2{data[15:0]}}.
- ISSUE->WAIT. In WAIT (T+2), mem_rdata is valid. The byte/halfword lane is selected by the registered addr[1:0], extended, and registered into rsp_rdata. Stores register 0. WAIT->RESP.
- RESP: rsp_valid=1 from T+3 for valid requests, T+1 for errors.
  - rsp_valid, rsp_rdata and rsp_err hold stable until rsp_ready.
  - On rsp_valid & rsp_ready the controller returns to IDLE and deasserts rsp_valid; req_ready=1 in the next cycle (no same-cycle re-accept).
- Sign extension: byte from bit 7, halfword from bit 15, unless the registered unsigned flag is set.
- mem_en, mem_we and mem_be are 0 in every state except ISSUE. mem_addr and mem_wdata hold their last value.
- Back-to-back throughput: one request per 4 cycles with rsp_ready tied high.

Test Plan:
- Reset with all outputs checked, then SW addr 0x4008 data 0xDEADBEEF -> mem_en at T+1, mem_addr=2, be=1111, wdata=0xDEADBEEF, mem_we=1; rsp_valid at T+3, err=00, rdata=0.
- LB addr 0x400B, mem_rdata=0x80FF_1234 -> be=1000, rsp_rdata=0xFFFFFF80. LBU, same stimulus -> rsp_rdata=0x00000080.
- SH addr 0x4006 data 0x0000_A55A -> mem_addr=1, be=1100, wdata=0xA55AA55A. LH addr 0x4006, mem_rdata=0x8001_0000 -> rsp_rdata=0xFFFF8001.
- Errors:
  - LW 0x4002 -> err=01, rsp at T+1, no mem_en.
  - LW 0x3FFC -> err=10.
  - LW 0x10000 -> err=10.
  - n_bytes=11 at addr 0x4001 -> err=11 (priority over misaligned).
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, extra req_valid ignored. Raise rsp_ready -> idle next cycle, req_ready=1.
- Assert rstn=0 during ISSUE of an SW -> all outputs at reset values immediately, no response after release, next LW completes normally.

Source files
------------

// File: rtl/lsu_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_dmem_ctrl
// Purpose  : Load/store controller between the RV32I memory stage and a
//            word-organised data memory. Takes one request at a time, checks
//            size encoding, alignment and address range, drives the DMEM with
//            byte enables and lane-replicated write data, and returns
//            extended load data or an error code over a valid/ready response.
// Ports    : clk, rstn             - clock, async active-low reset
//            req_*                 - core request channel (valid/ready)
//            rsp_*                 - response channel (valid/ready)
//            mem_*                 - DMEM strobe, write, word address,
//                                    byte enables, write/read data
// Revision : 1.0 - initial release
// ============================================================================
module lsu_dmem_ctrl #(
    parameter logic [31:0] DMEM_BASE  = 32'h0000_4000,
    parameter int          DMEM_BYTES = 49152,
    parameter int          DMEM_AW    = 14
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    input  logic [1:0]         req_n_bytes,
    input  logic               req_unsigned,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_rdata,
    output logic [1:0]         rsp_err,
    output logic               mem_en,
    output logic               mem_we,
    output logic [DMEM_AW-1:0] mem_addr,
    output logic [3:0]         mem_be,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] c_sz_word = 2'b00;
    localparam logic [1:0] c_sz_byte = 2'b01;
    localparam logic [1:0] c_sz_half = 2'b10;
    localparam logic [1:0] c_sz_ill  = 2'b11;

    localparam logic [1:0] c_err_ok    = 2'b00;
    localparam logic [1:0] c_err_align = 2'b01;
    localparam logic [1:0] c_err_range = 2'b10;
    localparam logic [1:0] c_err_size  = 2'b11;

    // Window bounds in 33 bits so base+size never wraps past 2^32.
    localparam logic [32:0] c_lo = {1'b0, DMEM_BASE};
    localparam logic [32:0] c_hi = {1'b0, DMEM_BASE} + 33'(DMEM_BYTES);

    state_t      r_state;
    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_we;

    logic [32:0] w_addr33;
    logic        w_illegal;
    logic        w_misalign;
    logic        w_range;
    logic [1:0]  w_err;
    logic [31:0] w_offset;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld;
    logic        w_unused_offset;

    // ------------------------------------------------------------------
    // Request decode (evaluated on the accept cycle)
    // ------------------------------------------------------------------
    assign w_addr33   = {1'b0, req_addr};
    assign w_illegal  = (req_n_bytes == c_sz_ill);
    assign w_misalign = ((req_n_bytes == c_sz_word) && (req_addr[1:0] != 2'b00)) ||
                        ((req_n_bytes == c_sz_half) && req_addr[0]);
    assign w_range    = (w_addr33 < c_lo) || (w_addr33 >= c_hi);
    assign w_offset   = req_addr - DMEM_BASE;
    // Only the word-index bits of the offset reach the memory port.
    assign w_unused_offset = ^w_offset;

    always_comb begin
        w_err = c_err_ok;
        if (w_illegal) begin
            w_err = c_err_size;
        end else if (w_misalign) begin
            w_err = c_err_align;
        end else if (w_range) begin
            w_err = c_err_range;
        end
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
        case (req_n_bytes)
            c_sz_byte: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            c_sz_half: begin
                w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load lane select and extension (uses the registered request)
    // ------------------------------------------------------------------
    always_comb begin
        case (r_lane)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_size)
            c_sz_byte: w_ld = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            c_sz_half: w_ld = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default:   w_ld = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_lane     <= 2'b00;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_we       <= 1'b0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= c_err_ok;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= 4'b0000;
            mem_wdata  <= 32'h0;
        end else begin
            // Strobes are single-cycle; they are only set on the accept edge,
            // so they are high exactly during ISSUE.
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_be <= 4'b0000;
            case (r_state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        r_lane     <= req_addr[1:0];
                        r_size     <= req_n_bytes;
                        r_unsigned <= req_unsigned;
                        r_we       <= req_we;
                        if (w_err != c_err_ok) begin
                            rsp_err   <= w_err;
                            rsp_rdata <= 32'h0;
                            rsp_valid <= 1'b1;
                            r_state   <= S_RESP;
                        end else begin
                            rsp_err   <= c_err_ok;
                            mem_en    <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= w_offset[DMEM_AW+1:2];
                            mem_be    <= w_be;
                            mem_wdata <= w_wdata;
                            r_state   <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    rsp_rdata <= r_we ? 32'h0 : w_ld;
                    rsp_valid <= 1'b1;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_dmem_ctrl
// Purpose  : Self-checking bench for lsu_dmem_ctrl. A transaction-level model
//            (byte-addressed memory image, per-request age counter) predicts
//            every output on every cycle; directed transactions pin the model
//            with literal values, then randomized traffic exercises the rest.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_dmem_ctrl;

    localparam logic [31:0] BASE  = 32'h0000_4000;
    localparam int          BYTES = 49152;
    localparam int          AW    = 14;
    localparam int          WORDS = BYTES / 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [31:0]   req_addr = 32'h0;
    logic [31:0]   req_wdata = 32'h0;
    logic [1:0]    req_n_bytes = 2'b00;
    logic          req_unsigned = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'h0;

    int n_chk  = 0;
    int n_fail = 0;

    lsu_dmem_ctrl #(
        .DMEM_BASE (BASE),
        .DMEM_BYTES(BYTES),
        .DMEM_AW   (AW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_n_bytes (req_n_bytes),
        .req_unsigned(req_unsigned),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // DMEM array seen by the DUT (word organised, one-cycle read latency)
    // ------------------------------------------------------------------
    logic [31:0] dwords [0:WORDS-1] = '{default: 32'h0};

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int k = 0; k < 4; k++)
                    if (mem_be[k]) dwords[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
            end else begin
                mem_rdata <= dwords[mem_addr];
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: byte-addressed image + transaction age
    // ------------------------------------------------------------------
    logic [7:0]  mbytes [0:BYTES-1] = '{default: 8'h0};
    bit          busy = 1'b0;
    int          age = 0;
    logic        t_we = 1'b0;
    logic [31:0] t_addr = 32'h0;
    logic [31:0] t_data = 32'h0;
    logic [1:0]  t_nb = 2'b00;
    logic        t_uns = 1'b0;
    logic [1:0]  t_err = 2'b00;
    logic [31:0] e_rdata = 32'h0;

    function automatic int size_of(input logic [1:0] nb);
        return (nb == 2'b00) ? 4 : (nb == 2'b01) ? 1 : (nb == 2'b10) ? 2 : 0;
    endfunction

    function automatic logic [1:0] err_of(input logic [31:0] a, input logic [1:0] nb);
        if (nb == 2'b11) return 2'b11;
        if ((a % 32'(size_of(nb))) != 0) return 2'b01;
        if (longint'(a) < longint'(BASE) || longint'(a) >= longint'(BASE) + longint'(BYTES))
            return 2'b10;
        return 2'b00;
    endfunction

    function automatic int lat_of(input logic [1:0] e);
        return (e != 2'b00) ? 1 : 3;
    endfunction

    function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [1:0] nb);
        logic [3:0] b;
        int lo;
        lo = int'(a[1:0]);
        for (int k = 0; k < 4; k++) b[k] = (k >= lo) && (k < lo + size_of(nb));
        return b;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [31:0] d, input logic [1:0] nb);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) begin
            case (nb)
                2'b01:   w[8*k +: 8] = d[7:0];
                2'b10:   w[8*k +: 8] = d[8*(k%2) +: 8];
                default: w[8*k +: 8] = d[8*k +: 8];
            endcase
        end
        return w;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] a, input logic [1:0] nb,
                                             input logic uns);
        logic [31:0] v;
        int sz, off;
        v   = 32'h0;
        sz  = size_of(nb);
        off = int'(a - BASE);
        for (int k = 0; k < sz; k++) v[8*k +: 8] = mbytes[off + k];
        if (!uns && sz < 4 && v[8*sz-1])
            for (int k = sz; k < 4; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy <= 1'b0;
            age  <= 0;
        end else if (!busy) begin
            if (req_valid) begin
                busy    <= 1'b1;
                age     <= 1;
                t_we    <= req_we;
                t_addr  <= req_addr;
                t_data  <= req_wdata;
                t_nb    <= req_n_bytes;
                t_uns   <= req_unsigned;
                t_err   <= err_of(req_addr, req_n_bytes);
                e_rdata <= 32'h0;
            end
        end else begin
            // The access commits when the strobe cycle completes.
            if (t_err == 2'b00 && age == 1) begin
                if (t_we) begin
                    for (int k = 0; k < size_of(t_nb); k++)
                        mbytes[int'(t_addr - BASE) + k] <= t_data[8*k +: 8];
                end else begin
                    e_rdata <= load_val(t_addr, t_nb, t_uns);
                end
            end
            if (age >= lat_of(t_err) && rsp_ready) busy <= 1'b0;
            else if (age < 1000) age <= age + 1;
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle comparison against the model
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rstn) begin
            chk("rst_req_ready", 32'(req_ready), 32'd1);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'h0);
            chk("rst_rsp_err",   32'(rsp_err), 32'd0);
            chk("rst_mem_en",    32'(mem_en), 32'd0);
            chk("rst_mem_we",    32'(mem_we), 32'd0);
            chk("rst_mem_addr",  32'(mem_addr), 32'd0);
            chk("rst_mem_be",    32'(mem_be), 32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'h0);
        end else begin
            chk("req_ready", 32'(req_ready), 32'(!busy));
            chk("rsp_valid", 32'(rsp_valid), 32'(busy && age >= lat_of(t_err)));
            if (busy && age >= lat_of(t_err)) begin
                chk("rsp_err",   32'(rsp_err), 32'(t_err));
                chk("rsp_rdata", rsp_rdata, e_rdata);
            end
            chk("mem_en", 32'(mem_en), 32'(busy && t_err == 2'b00 && age == 1));
            chk("mem_we", 32'(mem_we), 32'(busy && t_err == 2'b00 && age == 1 && t_we));
            chk("mem_be", 32'(mem_be),
                (busy && t_err == 2'b00 && age == 1) ? 32'(exp_be(t_addr, t_nb)) : 32'd0);
            if (busy && t_err == 2'b00 && age == 1) begin
                chk("mem_addr",  32'(mem_addr), ((t_addr - BASE) >> 2) & ((32'd1 << AW) - 1));
                chk("mem_wdata", mem_wdata, exp_wd(t_data, t_nb));
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver: one complete transaction, called and returning on a negedge
    // ------------------------------------------------------------------
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] nb, input logic uns, input int bp,
                          output logic [31:0] rd, output logic [1:0] er, output int lat,
                          output int mcyc, output logic [3:0] mbe,
                          output logic [31:0] maddr, output logic [31:0] mwd,
                          output logic mwe);
        int n;
        rd = 32'h0; er = 2'b00; lat = 0; mcyc = 0; mbe = 4'h0; maddr = 32'h0;
        mwd = 32'h0; mwe = 1'b0;
        req_we = we; req_addr = addr; req_wdata = data; req_n_bytes = nb;
        req_unsigned = uns; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            if (mem_en && mcyc == 0) begin
                mcyc = lat; mbe = mem_be; maddr = 32'(mem_addr); mwd = mem_wdata; mwe = mem_we;
            end
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        rd = rsp_rdata;
        er = rsp_err;
        // Backpressure: further requests offered meanwhile must be ignored.
        for (int i = 0; i < bp; i++) begin
            req_valid = 1'b1;
            req_we = 1'($urandom);
            req_addr = BASE + ($urandom % 64);
            req_wdata = $urandom;
            req_n_bytes = 2'($urandom);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    logic [31:0] rd, ma, mwd, a;
    logic [1:0]  er, nb;
    logic [3:0]  mbe;
    logic        mwe;
    int          lat, mc;

    initial begin
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("init_req_ready", 32'(req_ready), 32'd1);
        chk("init_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("init_mem_en",    32'(mem_en), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // SW 0x4008
        do_txn(1'b1, 32'h4008, 32'hDEADBEEF, 2'b00, 1'b0, 0, rd, er, lat, mc, mbe, ma, mwd, mwe);
        chk("sw_mem_cycle", 32'(mc), 32'd1);
        chk("sw_mem_addr",  ma, 32'd2);
        chk("sw_mem_be",    32'(mbe), 32'hF);
        chk("sw_mem_wdata", mwd, 32'hDEADBEEF);
        chk("sw_mem_we",    32'(mwe), 32'd1);
        chk("sw_latency",   32'(lat), 32'd3);
        chk("sw_err",       32'(er), 32'd0);
        chk("sw_rdata",     rd, 32'h0);

        // LB / LBU of the top byte of 0x80FF_1234
        do_txn(1'b1, 32'h4008, 32'h80FF1234, 2'b00, 1'b0, 0, rd, er, lat, mc, mbe, ma, mwd, mwe);
        do_txn(1'b0, 32'h400B, 32'h0, 2'b01, 1'b0, 0, rd, er, lat, mc, mbe, ma, mwd, mwe);
        chk("lb_mem_be", 32'(mbe), 32'h8);
        chk("lb_rdata",  rd, 32'hFFFFFF80);
        do_txn(1'b0, 32'h400B, 32'h0, 2'b01, 1'b1, 0, rd, er, lat, mc, mbe, ma, mwd, mwe);
        chk("lbu_rdata", rd, 32'h00000080);

        // SH / LH
        do_txn(1'b1, 32'h4006, 32'h0000A55A, 2'b10, 1'b0, 0, rd, er, lat, mc, mbe, ma, mwd, mwe);
        chk("sh_mem_addr",  ma, 32'd1);
        chk("sh_mem_be",    32'(mbe), 32'hC);
        chk("sh_mem_wdata", mwd, 32'hA55AA55A);
        do_txn(1'b1, 32'h4004, 32'h80010000, 2'b00, 1'b0, 0, rd, er, lat, mc, mbe, ma, mwd, mwe);
        do_txn(1'b0, 32'h4006, 32'h0, 2'b10, 1'b0, 0, rd, er, lat, mc, mbe, ma, mwd, mwe);
        chk("lh_rdata", rd, 32'hFFFF8001);

        // Errors
        do_txn(1'b0, 32'h4002, 32'h0, 2'b00, 1'b0, 0, rd, er, lat, mc, mbe, ma, mwd, mwe);
        chk("mis_err", 32'(er), 32'd1);
        chk("mis_latency", 32'(lat), 32'd1);
        chk("mis_no_mem_en", 32'(mc), 32'd0);
        chk("mis_rdata", rd, 32'h0);
        do_txn(1'b0, 32'h3FFC, 32'h0, 2'b00, 1'b0, 0, rd, er, lat, mc, mbe, ma, mwd, mwe);
        chk("low_range_err", 32'(er), 32'd2);
        do_txn(1'b0, 32'h10000, 32'h0, 2'b00, 1'b0, 0, rd, er, lat, mc, mbe, ma, mwd, mwe);
        chk("high_range_err", 32'(er), 32'd2);
        do_txn(1'b0, 32'hFFFC, 32'h0, 2'b00, 1'b0, 0, rd, er, lat, mc, mbe, ma, mwd, mwe);
        chk("last_word_err", 32'(er), 32'd0);
        do_txn(1'b0, 32'h4001, 32'h0, 2'b11, 1'b0, 0, rd, er, lat, mc, mbe, ma, mwd, mwe);
        chk("illegal_err", 32'(er), 32'd3);

        // Backpressure for 5 cycles with extra requests offered
        do_txn(1'b0, 32'h4008, 32'h0, 2'b00, 1'b0, 5, rd, er, lat, mc, mbe, ma, mwd, mwe);
        chk("bp_rdata", rd, 32'h80FF1234);

        // Reset during the ISSUE cycle of a store
        req_we = 1'b1; req_addr = 32'h4010; req_wdata = 32'h12345678;
        req_n_bytes = 2'b00; req_unsigned = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("abort_mem_en",    32'(mem_en), 32'd0);
        chk("abort_mem_we",    32'(mem_we), 32'd0);
        chk("abort_mem_be",    32'(mem_be), 32'd0);
        chk("abort_mem_addr",  32'(mem_addr), 32'd0);
        chk("abort_mem_wdata", mem_wdata, 32'h0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #2 rstn = 1'b1;
        repeat (5) @(negedge clk);
        do_txn(1'b0, 32'h4010, 32'h0, 2'b00, 1'b0, 0, rd, er, lat, mc, mbe, ma, mwd, mwe);
        chk("post_abort_err",   32'(er), 32'd0);
        chk("post_abort_rdata", rd, 32'h0);
        chk("post_abort_mc",    32'(mc), 32'd1);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            nb = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 9))
                7:       a = BASE + BYTES - 8 + $urandom_range(0, 15);
                8:       a = BASE - 8 + $urandom_range(0, 15);
                9:       a = $urandom;
                default: a = BASE + $urandom_range(0, 63);
            endcase
            if ($urandom_range(0, 3) != 0) begin
                if (nb == 2'b00) a = a & ~32'h3;
                if (nb == 2'b10) a = a & ~32'h1;
            end
            do_txn(1'($urandom), a, $urandom, nb, 1'($urandom), $urandom_range(0, 3),
                   rd, er, lat, mc, mbe, ma, mwd, mwe);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
